// File: rtl/prbs_pattern_gen.sv
// Burst capture with LIFO replay (n passes), then a free-running PRBS7/9/15/23 word stream.
// Optional PRBS_ERR_INJECT_EN adds ErrInject, which flips bit 0 of one PRBS word.
module prbs_pattern_gen #(
  parameter int unsigned BUS_WIDTH = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned NUM_WIDTH = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 InValid,
  input  logic [BUS_WIDTH-1:0] InData,
  input  logic [NUM_WIDTH-1:0] n,
  input  logic [1:0]           Mode,
  input  logic                 Restart,
`ifdef PRBS_ERR_INJECT_EN
  input  logic                 ErrInject,
`endif
  output logic [BUS_WIDTH-1:0] OutData,
  output logic                 OutValid,
  output logic                 PRBSEq,
  output logic                 Busy
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StReplay, StPrbs} state_e;

  state_e                 state_q, state_d;
  logic [IdxW-1:0]        wr_idx_q, wr_idx_d;
  logic [IdxW-1:0]        cur_q, cur_d;
  logic [NUM_WIDTH-1:0]   pass_q, pass_d;
  logic [1:0]             mode_q, mode_d;
  logic [22:0]            lfsr_q, lfsr_d;
  logic [BUS_WIDTH-1:0]   out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic                   prbs_eq_q, prbs_eq_d;
  logic                   busy_q, busy_d;
  logic [BUS_WIDTH-1:0]   mem_q [DEPTH];
  logic                   mem_we;

  logic [1:0]             pmode;
  logic [22:0]            psrc, pnext, lfsr_w, mask;
  logic [4:0]             hi, tp;
  logic                   fb;
  logic [BUS_WIDTH-1:0]   pword, inj;

`ifdef PRBS_ERR_INJECT_EN
  assign inj = BUS_WIDTH'(ErrInject);
`else
  assign inj = '0;
`endif

  // One word of PRBS: from the live LFSR in StPrbs, otherwise from a fresh all-ones seed.
  always_comb begin
    pmode = (state_q == StIdle || state_q == StLoad) ? Mode : mode_q;
    psrc  = (state_q == StPrbs) ? lfsr_q : '1;
    case (pmode)
      2'd0:    begin hi = 5'd6;  tp = 5'd5;  mask = 23'h00007F; end
      2'd1:    begin hi = 5'd8;  tp = 5'd4;  mask = 23'h0001FF; end
      2'd2:    begin hi = 5'd14; tp = 5'd13; mask = 23'h007FFF; end
      default: begin hi = 5'd22; tp = 5'd17; mask = 23'h7FFFFF; end
    endcase
    lfsr_w = psrc & mask;
    pword  = '0;
    fb     = 1'b0;
    for (int i = 0; i < int'(BUS_WIDTH); i++) begin
      fb = lfsr_w[hi] ^ lfsr_w[tp];
      lfsr_w = ((lfsr_w << 1) | {22'd0, fb}) & mask;
      pword[int'(BUS_WIDTH) - 1 - i] = fb;
    end
    pnext = lfsr_w;
  end

  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    cur_d       = cur_q;
    pass_d      = pass_q;
    mode_d      = mode_q;
    lfsr_d      = lfsr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    prbs_eq_d   = prbs_eq_q;
    busy_d      = busy_q;
    mem_we      = 1'b0;

    unique case (state_q)
      StIdle, StLoad: begin
        if (InValid) begin
          mem_we = 1'b1;
          if (wr_idx_q == LastIdx) begin
            wr_idx_d = '0;
            mode_d   = Mode;
            if (n == '0) begin
              state_d = StPrbs;
            end else begin
              state_d     = StReplay;
              cur_d       = LastIdx;
              pass_d      = n - NUM_WIDTH'(1);
              out_data_d  = InData;
              out_valid_d = 1'b1;
              busy_d      = 1'b1;
            end
          end else begin
            wr_idx_d = wr_idx_q + IdxW'(1);
            state_d  = StLoad;
          end
        end
      end
      StReplay: begin
        if (cur_q == '0 && pass_q == '0) begin
          state_d = StPrbs;
        end else if (cur_q == '0) begin
          cur_d      = LastIdx;
          pass_d     = pass_q - NUM_WIDTH'(1);
          out_data_d = mem_q[LastIdx];
        end else begin
          cur_d      = cur_q - IdxW'(1);
          out_data_d = mem_q[cur_q - IdxW'(1)];
        end
      end
      default: ;
    endcase

    // Covers both PRBS entry and steady PRBS; LFSR advances without the injected flip.
    if (state_d == StPrbs) begin
      out_data_d  = pword ^ inj;
      lfsr_d      = pnext;
      out_valid_d = 1'b1;
      prbs_eq_d   = 1'b1;
      busy_d      = 1'b1;
    end

    if (Restart) begin
      state_d     = StIdle;
      wr_idx_d    = '0;
      cur_d       = '0;
      pass_d      = '0;
      mode_d      = '0;
      lfsr_d      = '1;
      out_data_d  = '0;
      out_valid_d = 1'b0;
      prbs_eq_d   = 1'b0;
      busy_d      = 1'b0;
      mem_we      = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      wr_idx_q    <= '0;
      cur_q       <= '0;
      pass_q      <= '0;
      mode_q      <= '0;
      lfsr_q      <= '1;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      prbs_eq_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      cur_q       <= cur_d;
      pass_q      <= pass_d;
      mode_q      <= mode_d;
      lfsr_q      <= lfsr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      prbs_eq_q   <= prbs_eq_d;
      busy_q      <= busy_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we && !RST) begin
      mem_q[wr_idx_q] <= InData;
    end
  end

  assign OutData  = out_data_q;
  assign OutValid = out_valid_q;
  assign PRBSEq   = prbs_eq_q;
  assign Busy     = busy_q;

endmodule

// File: tb/tb_prbs_pattern_gen.sv
// Directed bench for prbs_pattern_gen: replay order, gaps, Restart/RST, PRBS7/15 words.
module tb_prbs_pattern_gen;

  logic       clk = 1'b0;
  logic       rst, in_valid, restart;
  logic [7:0] in_data;
  logic [3:0] num;
  logic [1:0] mode;
  logic [7:0] out_data;
  logic       out_valid, prbs_eq, busy;
`ifdef PRBS_ERR_INJECT_EN
  logic       err_inject = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] mdl [$];
  logic [7:0] obs [255];

  prbs_pattern_gen #(.BUS_WIDTH(8), .DEPTH(4), .NUM_WIDTH(4)) dut (
    .CLK      (clk),
    .RST      (rst),
    .InValid  (in_valid),
    .InData   (in_data),
    .n        (num),
    .Mode     (mode),
    .Restart  (restart),
`ifdef PRBS_ERR_INJECT_EN
    .ErrInject(err_inject),
`endif
    .OutData  (out_data),
    .OutValid (out_valid),
    .PRBSEq   (prbs_eq),
    .Busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Independent bit-recurrence model: s[k] = s[k-L] ^ s[k-tap], seed L ones.
  task automatic gen_model(input int m, input int cnt);
    int len, tap;
    bit seq [$];
    logic [7:0] w;
    len = (m == 0) ? 7 : (m == 1) ? 9 : (m == 2) ? 15 : 23;
    tap = (m == 0) ? 6 : (m == 1) ? 5 : (m == 2) ? 14 : 18;
    mdl.delete();
    for (int k = 0; k < len; k++) seq.push_back(1'b1);
    for (int k = 0; k < cnt * 8; k++) seq.push_back(seq[k] ^ seq[k + len - tap]);
    for (int j = 0; j < cnt; j++) begin
      for (int b = 0; b < 8; b++) w[7 - b] = seq[len + j * 8 + b];
      mdl.push_back(w);
    end
  endtask

  task automatic load4(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d);
    logic [7:0] v [4];
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = v[i];
      tick();
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic pulse_restart;
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_w [4];
    logic [7:0] gdata [7];
    bit         gval  [7];

    rst = 1'b1; in_valid = 1'b0; restart = 1'b0; in_data = 8'h00; num = 4'd0; mode = 2'd0;
    tick();
    tick();
    rst = 1'b0;
    check_eq("rst_outdata", out_data, 8'h00);
    check_eq("rst_outvalid", out_valid, 1'b0);
    check_eq("rst_prbseq", prbs_eq, 1'b0);
    check_eq("rst_busy", busy, 1'b0);

    // Contiguous load, n=4, PRBS15
    mode = 2'd2; num = 4'd4;
    load4(8'hAA, 8'hBB, 8'hCC, 8'hDD);
    num = 4'd0; mode = 2'd3;
    exp_w[0] = 8'hDD; exp_w[1] = 8'hCC; exp_w[2] = 8'hBB; exp_w[3] = 8'hAA;
    check_eq("replay_valid", out_valid, 1'b1);
    check_eq("replay_busy", busy, 1'b1);
    for (int c = 0; c < 16; c++) begin
      check_eq($sformatf("replay_c%0d", c), out_data, exp_w[c % 4]);
      if (c == 15) check_eq("replay_last_eq", prbs_eq, 1'b0);
      tick();
    end
    check_eq("prbs15_eq", prbs_eq, 1'b1);
    check_eq("prbs15_w0", out_data, 8'h00);
    tick();
    check_eq("prbs15_w1", out_data, 8'h02);

    // n=0, PRBS7 straight after load; compare 255 words
    pulse_restart();
    check_eq("restart_valid", out_valid, 1'b0);
    mode = 2'd0; num = 4'd0;
    gen_model(0, 255);
    load4(8'h01, 8'h02, 8'h03, 8'h04);
    check_eq("prbs7_eq", prbs_eq, 1'b1);
    check_eq("prbs7_w0_hand", out_data, 8'h02);
    for (int w = 0; w < 255; w++) begin
      obs[w] = out_data;
      check_eq($sformatf("prbs7_w%0d", w), out_data, mdl[w]);
      tick();
    end
    check_eq("prbs7_w1_hand", obs[1], 8'h0C);
    check_eq("prbs7_period", obs[127], 8'h02);

    // Gapped load, n=1, PRBS15
    pulse_restart();
    mode = 2'd2; num = 4'd1;
    gval[0] = 1; gval[1] = 0; gval[2] = 0; gval[3] = 1; gval[4] = 1; gval[5] = 0; gval[6] = 1;
    gdata[0] = 8'h10; gdata[1] = 8'hEE; gdata[2] = 8'hEE; gdata[3] = 8'h20;
    gdata[4] = 8'h30; gdata[5] = 8'hEE; gdata[6] = 8'h40;
    for (int i = 0; i < 7; i++) begin
      in_valid = gval[i];
      in_data  = gdata[i];
      tick();
      if (i < 6) check_eq($sformatf("gap_valid%0d", i), out_valid, 1'b0);
    end
    in_valid = 1'b0;
    exp_w[0] = 8'h40; exp_w[1] = 8'h30; exp_w[2] = 8'h20; exp_w[3] = 8'h10;
    for (int c = 0; c < 4; c++) begin
      check_eq($sformatf("gap_replay%0d", c), out_data, exp_w[c]);
      tick();
    end
    check_eq("gap_prbs_eq", prbs_eq, 1'b1);
    check_eq("gap_prbs_w0", out_data, 8'h00);

    // Restart on 3rd replay cycle, then immediate reload
    pulse_restart();
    mode = 2'd2; num = 4'd2;
    load4(8'h01, 8'h02, 8'h03, 8'h04);
    tick();
    tick();
    check_eq("mid_replay_w", out_data, 8'h02);
    pulse_restart();
    check_eq("rs_valid", out_valid, 1'b0);
    check_eq("rs_busy", busy, 1'b0);
    check_eq("rs_prbseq", prbs_eq, 1'b0);
    mode = 2'd0; num = 4'd1;
    load4(8'h11, 8'h22, 8'h33, 8'h44);
    exp_w[0] = 8'h44; exp_w[1] = 8'h33; exp_w[2] = 8'h22; exp_w[3] = 8'h11;
    for (int c = 0; c < 4; c++) begin
      check_eq($sformatf("reload_replay%0d", c), out_data, exp_w[c]);
      tick();
    end
    check_eq("reload_prbs_w0", out_data, 8'h02);
    tick();
    tick();

    // RST in PRBS, then PRBS restarts from seed
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("prst_outdata", out_data, 8'h00);
    check_eq("prst_valid", out_valid, 1'b0);
    check_eq("prst_prbseq", prbs_eq, 1'b0);
    check_eq("prst_busy", busy, 1'b0);
    mode = 2'd0; num = 4'd0;
    load4(8'h05, 8'h06, 8'h07, 8'h08);
    check_eq("prst_w0", out_data, 8'h02);
    tick();
    check_eq("prst_w1", out_data, 8'h0C);

`ifdef PRBS_ERR_INJECT_EN
    pulse_restart();
    gen_model(0, 4);
    load4(8'h01, 8'h02, 8'h03, 8'h04);
    check_eq("inj_w0", out_data, mdl[0]);
    err_inject = 1'b1;
    tick();
    err_inject = 1'b0;
    check_eq("inj_w1", out_data, mdl[1] ^ 8'h01);
    tick();
    check_eq("inj_w2", out_data, mdl[2]);
    tick();
    check_eq("inj_w3", out_data, mdl[3]);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
